// File: rtl/score_keeper.sv
// Game-control FSM: watches the ball column for goals, keeps both scores,
// gates ball motion through serve pauses and game over, and pulses ball_reset.
module score_keeper #(
  parameter int DISP_COLS   = 800,
  parameter int GOAL_MARGIN = 2,
  parameter int WIN_SCORE   = 9,
  parameter int PAUSE_TICKS = 5000000,
  parameter int CNT_WIDTH   = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] ball_center_col,
  output logic        ball_enable,
  output logic        ball_reset,
  output logic [3:0]  l_score,
  output logic [3:0]  r_score,
  output logic        game_over,
  output logic [1:0]  winner
);

  typedef enum logic [1:0] {IDLE, PAUSE, PLAY, OVER} state_t;

  localparam logic [11:0]          LEFT_LIM  = 12'(GOAL_MARGIN);
  localparam logic [11:0]          RIGHT_LIM = 12'(DISP_COLS - GOAL_MARGIN);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD  = CNT_WIDTH'(PAUSE_TICKS - 1);
  localparam logic [3:0]           WIN       = 4'(WIN_SCORE);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           l_q, l_d, r_q, r_d;
  logic [1:0]           win_q, win_d;
  logic                 brst_q, brst_d;
  logic                 ben_q, go_q;
  logic                 start_q, seen_low_q;
  logic                 start_rise;
  logic                 left_goal, right_goal;
  logic [3:0]           l_inc, r_inc;

  // A start held high across reset release must be lowered before it counts.
  assign start_rise = start & ~start_q & seen_low_q;
  assign left_goal  = (ball_center_col <= LEFT_LIM);
  assign right_goal = (ball_center_col >= RIGHT_LIM);
  assign l_inc      = l_q + 4'd1;
  assign r_inc      = r_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    win_d   = win_q;
    brst_d  = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          l_d     = 4'd0;
          r_d     = 4'd0;
          win_d   = 2'b00;
          brst_d  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (cnt_q == '0) state_d = PLAY;
        else             cnt_d   = cnt_q - 1'b1;
      end
      PLAY: begin
        // Left goal takes priority if both edges match in one cycle.
        if (left_goal) begin
          r_d    = r_inc;
          brst_d = 1'b1;
          if (r_inc == WIN) begin
            win_d   = 2'b10;
            state_d = OVER;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = PAUSE;
          end
        end else if (right_goal) begin
          l_d    = l_inc;
          brst_d = 1'b1;
          if (l_inc == WIN) begin
            win_d   = 2'b01;
            state_d = OVER;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = PAUSE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      l_q        <= 4'd0;
      r_q        <= 4'd0;
      win_q      <= 2'b00;
      brst_q     <= 1'b0;
      ben_q      <= 1'b0;
      go_q       <= 1'b0;
      start_q    <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      l_q        <= l_d;
      r_q        <= r_d;
      win_q      <= win_d;
      brst_q     <= brst_d;
      ben_q      <= (state_d == PLAY);
      go_q       <= (state_d == OVER);
      start_q    <= start;
      seen_low_q <= seen_low_q | ~start;
    end
  end

  assign ball_enable = ben_q;
  assign ball_reset  = brst_q;
  assign l_score     = l_q;
  assign r_score     = r_q;
  assign game_over   = go_q;
  assign winner      = win_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with a short pause and a 3-point game.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] col;
  logic        ball_enable, ball_reset, game_over;
  logic [3:0]  l_score, r_score;
  logic [1:0]  winner;

  int tests = 0;
  int fails = 0;

  score_keeper #(
    .DISP_COLS(800), .GOAL_MARGIN(2), .WIN_SCORE(3),
    .PAUSE_TICKS(4), .CNT_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ball_center_col(col),
    .ball_enable(ball_enable), .ball_reset(ball_reset),
    .l_score(l_score), .r_score(r_score),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Called at the negedge right after a serve decision edge.
  task automatic serve_check(input string tag);
    chk({tag, "_brst_on"}, 12'(ball_reset), 12'd1);
    chk({tag, "_ben_off"}, 12'(ball_enable), 12'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, "_brst_off"}, 12'(ball_reset), 12'd0);
      chk({tag, "_ben_pause"}, 12'(ball_enable), 12'd0);
    end
    step();
    chk({tag, "_ben_play"}, 12'(ball_enable), 12'd1);
  endtask

  task automatic scores(input string tag, input logic [3:0] l, input logic [3:0] r);
    chk({tag, "_l"}, 12'(l_score), 12'(l));
    chk({tag, "_r"}, 12'(r_score), 12'(r));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; col = 12'd400;
    step(); step();
    chk("rst_ben", 12'(ball_enable), 12'd0);
    chk("rst_brst", 12'(ball_reset), 12'd0);
    chk("rst_go", 12'(game_over), 12'd0);
    chk("rst_win", 12'(winner), 12'd0);
    scores("rst", 4'd0, 4'd0);
    rst = 1'b0;
    step(); step();
    chk("idle_ben", 12'(ball_enable), 12'd0);

    // first serve
    start = 1'b1;
    step();
    start = 1'b0;
    serve_check("serve1");

    // left-edge goal held 5 cycles -> exactly one point to the right player
    col = 12'd2;
    step();
    scores("goal_r1", 4'd0, 4'd1);
    serve_check("goal_r1");
    col = 12'd400;
    step();
    scores("hold2", 4'd0, 4'd1);

    // right-edge goal
    col = 12'd798;
    step();
    col = 12'd400;
    scores("goal_l1", 4'd1, 4'd1);
    serve_check("goal_l1");

    // just inside both margins
    col = 12'd3;
    step();
    scores("col3", 4'd1, 4'd1);
    chk("col3_brst", 12'(ball_reset), 12'd0);
    col = 12'd797;
    step();
    scores("col797", 4'd1, 4'd1);
    chk("col797_ben", 12'(ball_enable), 12'd1);

    col = 12'd2;
    step();
    col = 12'd400;
    scores("goal_r2", 4'd1, 4'd2);
    serve_check("goal_r2");

    // start pressed during PLAY is ignored, and stays held into OVER
    start = 1'b1;
    step();
    scores("play_start", 4'd1, 4'd2);
    col = 12'd2;
    step();
    scores("win", 4'd1, 4'd3);
    chk("win_go", 12'(game_over), 12'd1);
    chk("win_winner", 12'(winner), 12'h2);
    chk("win_ben", 12'(ball_enable), 12'd0);
    chk("win_brst", 12'(ball_reset), 12'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      scores("over_frozen", 4'd1, 4'd3);
      chk("over_go", 12'(game_over), 12'd1);
      chk("over_winner", 12'(winner), 12'h2);
      chk("over_brst", 12'(ball_reset), 12'd0);
      chk("over_ben", 12'(ball_enable), 12'd0);
    end

    // restart from OVER
    col = 12'd400;
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    scores("restart", 4'd0, 4'd0);
    chk("restart_winner", 12'(winner), 12'd0);
    chk("restart_go", 12'(game_over), 12'd0);
    serve_check("restart");

    // build 2/1 and reset mid-pause
    col = 12'd798;
    step();
    col = 12'd400;
    serve_check("l1");
    col = 12'd798;
    step();
    col = 12'd400;
    serve_check("l2");
    col = 12'd2;
    step();
    col = 12'd400;
    scores("pre_rst", 4'd2, 4'd1);
    step();
    start = 1'b1;
    #2 rst = 1'b1;
    #1;
    scores("async_rst", 4'd0, 4'd0);
    chk("async_rst_ben", 12'(ball_enable), 12'd0);
    chk("async_rst_brst", 12'(ball_reset), 12'd0);
    chk("async_rst_go", 12'(game_over), 12'd0);
    chk("async_rst_win", 12'(winner), 12'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_start_brst", 12'(ball_reset), 12'd0);
      chk("held_start_ben", 12'(ball_enable), 12'd0);
    end
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    serve_check("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
